pipe_stall_ctrl: RTL

Central pipeline controller for the 5-stage core. It produces the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, from per-stage stall requests. It also sequences multi-cycle EX operations (mul/div) with an internal busy counter, and generates the IF/ID flush on taken branches, including a deferred flush when a fetch is still in flight.

---
 rtl/pipe_stall_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush controller for the 5-stage core.
// Builds the 6-bit stall vector from per-stage requests and sequences
// multi-cycle EX ops (mul/div) with a down-counter.
// It also produces the IF/ID flush for taken branches. When a fetch is
// still in flight, the flush is deferred until that fetch completes.
// Optional feature: define STALL_PERF_EN to add the stall_cycles counter.
module pipe_stall_ctrl #(
    parameter int unsigned MC_LATENCY = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       if_stall_req,
    input  logic       id_stall_req,
    input  logic       ex_stall_req,
    input  logic       mem_stall_req,
    input  logic       ex_mc_start,
    input  logic       ex_branch_taken,
    output logic [5:0] stall,
    output logic       flush,
    output logic       ex_mc_busy,
    output logic       ex_mc_done
`ifdef STALL_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LATENCY - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] mc_cnt, mc_cnt_nxt;
    logic             flush_pending, flush_pending_nxt;
    logic             mc_hold;
    logic             cnt_zero;
    logic             ex_level;

    // Reserved hook for holding EX from inside the multi-cycle unit.
    assign mc_hold  = 1'b0;
    assign cnt_zero = (mc_cnt == '0);

    assign ex_level = ex_stall_req
                    | ((state == IDLE) & ex_mc_start)
                    | ((state == BUSY) & !cnt_zero)
                    | mc_hold;

    // The oldest stalled stage freezes itself and every younger stage.
    always_comb begin
        stall = 6'b000000;
        if (mem_stall_req)     stall = 6'b011111;
        else if (ex_level)     stall = 6'b001111;
        else if (id_stall_req) stall = 6'b000111;
        else if (if_stall_req) stall = 6'b000011;
    end

    assign ex_mc_busy = (state == BUSY);
    assign ex_mc_done = (state == BUSY) & cnt_zero;

    // Multi-cycle sequencing. While done is up, the FSM waits for EX/MEM to
    // become free so the result is captured before returning to IDLE.
    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        case (state)
            IDLE: begin
                if (ex_mc_start) begin
                    state_nxt  = BUSY;
                    mc_cnt_nxt = MC_LOAD;
                end
            end
            BUSY: begin
                if (!cnt_zero)      mc_cnt_nxt = mc_cnt - 1'b1;
                else if (!stall[3]) state_nxt  = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                mc_cnt_nxt = '0;
            end
        endcase
    end

    // A branch that resolves while a fetch is outstanding is remembered. The
    // bubble is then inserted once the fetch lands. Repeat branches merge.
    always_comb begin
        flush             = 1'b0;
        flush_pending_nxt = flush_pending;
        if (!if_stall_req) begin
            if ((ex_branch_taken && !stall[3]) || flush_pending) flush = 1'b1;
            flush_pending_nxt = 1'b0;
        end else if (ex_branch_taken && !stall[3]) begin
            flush_pending_nxt = 1'b1;
        end
    end

    // State, counter and pending-flush registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            mc_cnt        <= '0;
            flush_pending <= 1'b0;
        end else begin
            state         <= state_nxt;
            mc_cnt        <= mc_cnt_nxt;
            flush_pending <= flush_pending_nxt;
        end
    end

`ifdef STALL_PERF_EN
    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                              stall_cycles <= '0;
        else if (stall[0] && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
`endif

endmodule
